// File: rtl/muscle_sched_pkg.sv
// Shared types for the muscle bank scheduler and its state bank.
// Build option MUSCLE_SCHED_SNAPSHOT_EN is consumed by muscle_state_bank.
package muscle_sched_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0;

  typedef struct packed {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y1;
    logic [31:0] y2;
    logic [31:0] T;
  } ch_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/muscle_state_bank.sv
// Per-channel spike/force history with issue and writeback shift ports.
// MUSCLE_SCHED_SNAPSHOT_EN: readout comes from a shadow captured at step end.
module muscle_state_bank
  import muscle_sched_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x_we,
  input  logic [CH_W-1:0] x_ch,
  input  logic [31:0]     x_in,
  input  logic            y_we,
  input  logic [CH_W-1:0] y_ch,
  input  logic [31:0]     h_in,
  input  logic [31:0]     t_in,
  input  logic [CH_W-1:0] iss_ch,
  output ch_state_t       iss_st,
  input  logic            snap,
  input  logic [CH_W-1:0] rd_ch,
  output logic [31:0]     rd_force
);

  ch_state_t bank [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        bank[i] <= '{FP_ZERO, FP_ZERO, FP_ZERO,
                     FP_ZERO, FP_ZERO};
    end else begin
      if (x_we) begin
        bank[x_ch].x2 <= bank[x_ch].x1;
        bank[x_ch].x1 <= x_in;
      end
      if (y_we) begin
        bank[y_ch].y2 <= bank[y_ch].y1;
        bank[y_ch].y1 <= h_in;
        bank[y_ch].T  <= t_in;
      end
    end
  end

  assign iss_st = bank[iss_ch];

`ifdef MUSCLE_SCHED_SNAPSHOT_EN
  logic [31:0] shadow [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= FP_ZERO;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++)
        shadow[i] <= bank[i].T;
    end
  end

  assign rd_force = shadow[rd_ch];
`else
  logic snap_unused;
  assign snap_unused = snap;
  assign rd_force    = bank[rd_ch].T;
`endif

endmodule

// File: rtl/muscle_bank_scheduler.sv
// Issues every muscle channel once per tick to the shared force datapath.
// MUSCLE_SCHED_SNAPSHOT_EN selects a step-stable force readout.
module muscle_bank_scheduler
  import muscle_sched_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int DP_LAT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_tick,
  input  logic            i_clr_err,
  output logic [CH_W-1:0] o_src_ch,
  input  logic [31:0]     i_spike_cnt,
  input  logic [31:0]     i_spike_fp,
  output logic            o_dp_valid,
  output logic [CH_W-1:0] o_dp_ch,
  output logic [31:0]     o_dp_x1,
  output logic [31:0]     o_dp_x2,
  output logic [31:0]     o_dp_y1,
  output logic [31:0]     o_dp_y2,
  output logic [31:0]     o_dp_T,
  input  logic            i_dp_valid,
  input  logic [CH_W-1:0] i_dp_ch,
  input  logic [31:0]     i_dp_h,
  input  logic [31:0]     i_dp_T,
  input  logic [CH_W-1:0] i_rd_ch,
  output logic [31:0]     o_rd_force,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_overrun,
  output logic            o_seq_err
);

  localparam logic [CH_W:0]   LAST_EXP = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W:0]   PREV_EXP = (CH_W+1)'(NUM_CH - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  sched_state_t    state;
  logic [CH_W-1:0] iss_cnt;
  logic [CH_W:0]   exp_cnt;
  ch_state_t       iss_st;

  logic issuing;
  logic wb;
  logic all_in;
  logic ovr_ev;
  logic seq_ev;

  assign issuing = (state == S_ISSUE);
  assign wb      = i_dp_valid && (state != S_IDLE);
  assign all_in  = (exp_cnt == LAST_EXP) ||
                   (wb && exp_cnt == PREV_EXP);
  assign ovr_ev  = i_tick && (state != S_IDLE);
  assign seq_ev  = i_dp_valid &&
                   (state == S_IDLE || state == S_DONE ||
                    exp_cnt == LAST_EXP ||
                    i_dp_ch != exp_cnt[CH_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      iss_cnt   <= '0;
      exp_cnt   <= '0;
      o_overrun <= 1'b0;
      o_seq_err <= 1'b0;
    end else begin
      o_overrun <= (o_overrun & ~i_clr_err) | ovr_ev;
      o_seq_err <= (o_seq_err & ~i_clr_err) | seq_ev;
      if (wb && exp_cnt != LAST_EXP)
        exp_cnt <= exp_cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (i_tick) begin
            state   <= S_ISSUE;
            iss_cnt <= '0;
            exp_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (iss_cnt == LAST_CH)
            state <= S_DRAIN;
          else
            iss_cnt <= iss_cnt + 1'b1;
        end
        S_DRAIN: begin
          if (all_in)
            state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  muscle_state_bank #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .x_we     (issuing),
    .x_ch     (iss_cnt),
    .x_in     (i_spike_fp),
    .y_we     (wb),
    .y_ch     (i_dp_ch),
    .h_in     (i_dp_h),
    .t_in     (i_dp_T),
    .iss_ch   (iss_cnt),
    .iss_st   (iss_st),
    .snap     (state == S_DONE),
    .rd_ch    (i_rd_ch),
    .rd_force (o_rd_force)
  );

  // Datapath sees post-shift history: x[i-1] is this step's spike.
  assign o_src_ch   = iss_cnt;
  assign o_dp_ch    = iss_cnt;
  assign o_dp_valid = issuing;
  assign o_dp_x1    = i_spike_fp;
  assign o_dp_x2    = iss_st.x1;
  assign o_dp_y1    = iss_st.y1;
  assign o_dp_y2    = iss_st.y2;
  assign o_dp_T     = iss_st.T;
  assign o_busy     = (state != S_IDLE);
  assign o_done     = (state == S_DONE);

  logic x2_unused;
  logic cnt_unused;
  logic lat_unused;
  assign x2_unused  = ^iss_st.x2;
  assign cnt_unused = ^i_spike_cnt;
  assign lat_unused = (DP_LAT > 0);

endmodule

// File: tb/tb_muscle_bank_scheduler.sv
// Bench for muscle_bank_scheduler: step-level reference model plus
// a fixed-latency datapath responder and directed corner cases.
module tb_muscle_bank_scheduler;

  localparam int NUM_CH   = 8;
  localparam int CH_W     = 3;
  localparam int DP_LAT   = 4;
  localparam int DONE_REL = NUM_CH + DP_LAT + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_tick = 1'b0;
  logic            i_clr_err = 1'b0;
  logic [CH_W-1:0] o_src_ch;
  logic [31:0]     i_spike_cnt;
  logic [31:0]     i_spike_fp;
  logic            o_dp_valid;
  logic [CH_W-1:0] o_dp_ch;
  logic [31:0]     o_dp_x1, o_dp_x2, o_dp_y1, o_dp_y2, o_dp_T;
  logic            i_dp_valid = 1'b0;
  logic [CH_W-1:0] i_dp_ch = '0;
  logic [31:0]     i_dp_h = '0;
  logic [31:0]     i_dp_T = '0;
  logic [CH_W-1:0] i_rd_ch = '0;
  logic [31:0]     o_rd_force;
  logic            o_busy, o_done, o_overrun, o_seq_err;

  muscle_bank_scheduler #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DP_LAT (DP_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_tick      (i_tick),
    .i_clr_err   (i_clr_err),
    .o_src_ch    (o_src_ch),
    .i_spike_cnt (i_spike_cnt),
    .i_spike_fp  (i_spike_fp),
    .o_dp_valid  (o_dp_valid),
    .o_dp_ch     (o_dp_ch),
    .o_dp_x1     (o_dp_x1),
    .o_dp_x2     (o_dp_x2),
    .o_dp_y1     (o_dp_y1),
    .o_dp_y2     (o_dp_y2),
    .o_dp_T      (o_dp_T),
    .i_dp_valid  (i_dp_valid),
    .i_dp_ch     (i_dp_ch),
    .i_dp_h      (i_dp_h),
    .i_dp_T      (i_dp_T),
    .i_rd_ch     (i_rd_ch),
    .o_rd_force  (o_rd_force),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overrun   (o_overrun),
    .o_seq_err   (o_seq_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] spike_tab [NUM_CH];
  assign i_spike_fp  = spike_tab[o_src_ch];
  assign i_spike_cnt = 32'(o_src_ch);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] m_x1 [NUM_CH];
  logic [31:0] m_y1 [NUM_CH];
  logic [31:0] m_y2 [NUM_CH];
  logic [31:0] m_T  [NUM_CH];
  logic [31:0] m_sh [NUM_CH];
  bit m_run = 0;
  int m_rel = 0;
  int m_res = 0;
  bit m_ov = 0;
  bit m_se = 0;

  int done_cnt = 0;
  int done_cyc = 0;
  logic [31:0] cap_x1 [NUM_CH];
  logic [31:0] cap_x2 [NUM_CH];
  logic [31:0] cap_y1 [NUM_CH];

  typedef struct {
    int              due;
    logic [CH_W-1:0] ch;
    logic [31:0]     h;
    logic [31:0]     t;
  } res_t;
  res_t rq[$];

  int bad_cyc = -1;
  int inj_cyc = -1;

  // Compare process: expected outputs follow from tick time and rules
  always @(negedge clk) begin : cmp
    bit   issue;
    bit   done;
    bit   seq_ev;
    int   k;
    res_t r;
    if (reset) begin
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_valid", o_dp_valid, 0);
      chk("rst_src_ch", o_src_ch, 0);
      chk("rst_overrun", o_overrun, 0);
      chk("rst_seq_err", o_seq_err, 0);
      chk("rst_force", o_rd_force, 0);
      for (int i = 0; i < NUM_CH; i++) begin
        m_x1[i] = 0; m_y1[i] = 0; m_y2[i] = 0;
        m_T[i] = 0; m_sh[i] = 0;
      end
      m_run = 0; m_res = 0; m_ov = 0; m_se = 0;
    end else begin
      issue = m_run && m_rel <= NUM_CH;
      done  = m_run && m_rel == DONE_REL;
      k     = m_rel - 1;
      chk("busy", o_busy, m_run);
      chk("done", o_done, done);
      chk("dp_valid", o_dp_valid, issue);
      chk("overrun", o_overrun, m_ov);
      chk("seq_err", o_seq_err, m_se);
      if (issue) begin
        chk("dp_ch", o_dp_ch, k);
        chk("src_ch", o_src_ch, k);
        chk("dp_x1", o_dp_x1, i_spike_fp);
        chk("dp_x2", o_dp_x2, m_x1[k]);
        chk("dp_y1", o_dp_y1, m_y1[k]);
        chk("dp_y2", o_dp_y2, m_y2[k]);
        chk("dp_T", o_dp_T, m_T[k]);
        cap_x1[k] = o_dp_x1;
        cap_x2[k] = o_dp_x2;
        cap_y1[k] = o_dp_y1;
      end
`ifdef MUSCLE_SCHED_SNAPSHOT_EN
      chk("rd_force", o_rd_force, m_sh[i_rd_ch]);
`else
      chk("rd_force", o_rd_force, m_T[i_rd_ch]);
`endif
      if (o_dp_valid) begin
        r.due = cyc + DP_LAT;
        r.ch  = o_dp_ch;
        r.h   = o_dp_x1 ^ o_dp_y1 ^ o_dp_y2;
        r.t   = o_dp_x1 ^ o_dp_x2 ^ o_dp_T;
        rq.push_back(r);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      seq_ev = i_dp_valid && (!m_run || done ||
               m_res >= NUM_CH || int'(i_dp_ch) != m_res);
      m_ov = (m_ov && !i_clr_err) || (i_tick && m_run);
      m_se = (m_se && !i_clr_err) || seq_ev;
      if (done)
        for (int i = 0; i < NUM_CH; i++) m_sh[i] = m_T[i];
      if (i_dp_valid && m_run) begin
        m_y2[i_dp_ch] = m_y1[i_dp_ch];
        m_y1[i_dp_ch] = i_dp_h;
        m_T[i_dp_ch]  = i_dp_T;
        if (m_res < NUM_CH) m_res++;
      end
      if (issue) m_x1[k] = i_spike_fp;
      if (m_run) begin
        if (done) m_run = 0;
        else m_rel++;
      end else if (i_tick) begin
        m_run = 1; m_rel = 1; m_res = 0;
      end
    end
  end

  // Datapath stand-in: fixed latency, optional channel corruption
  always @(posedge clk) begin : rsp
    res_t r;
    #1;
    i_dp_valid = 1'b0;
    i_dp_ch    = '0;
    i_dp_h     = '0;
    i_dp_T     = '0;
    if (reset) begin
      rq.delete();
    end else if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      i_dp_valid = 1'b1;
      i_dp_ch    = (cyc == bad_cyc) ? CH_W'(r.ch + 1) : r.ch;
      i_dp_h     = r.h;
      i_dp_T     = r.t;
    end else if (cyc == inj_cyc) begin
      i_dp_valid = 1'b1;
      i_dp_ch    = '0;
      i_dp_h     = 32'hDEAD0001;
      i_dp_T     = 32'hDEAD0002;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spikes(input int ch, input logic [31:0] v);
    for (int i = 0; i < NUM_CH; i++) spike_tab[i] = 32'h0;
    spike_tab[ch] = v;
  endtask

  task automatic run_step(input bit rnd, input int ovr_rel,
                          output int lat);
    int tc;
    int d0;
    d0  = done_cnt;
    tc  = cyc;
    lat = -1;
    i_tick = 1'b1;
    nxt();
    for (int i = 1; i < 40; i++) begin
      i_tick = (i == ovr_rel) ||
               (rnd && i <= DONE_REL && $urandom_range(15) == 0);
      i_clr_err = rnd && $urandom_range(7) == 0;
      if (rnd) i_rd_ch = CH_W'($urandom_range(NUM_CH - 1));
      nxt();
      if (done_cnt != d0) begin
        lat = done_cyc - tc;
        break;
      end
    end
    i_tick    = 1'b0;
    i_clr_err = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic clr_flags();
    i_clr_err = 1'b1;
    nxt();
    i_clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int tc;
    int d0;
    for (int i = 0; i < NUM_CH; i++) spike_tab[i] = 32'h0;
    repeat (3) nxt();
    chk("lit_rst_busy", o_busy, 0);
    chk("lit_rst_force", o_rd_force, 32'h0);
    reset = 1'b0;
    nxt();

    // Single spike on channel 0
    set_spikes(0, 32'h3F800000);
    run_step(0, 0, lat);
    chk("t1_done_lat", lat, 13);
    i_rd_ch = 0; #1;
    chk("t1_rd_ch0", o_rd_force, 32'h3F800000);
    i_rd_ch = 1; #1;
    chk("t1_rd_ch1", o_rd_force, 32'h0);

    // Two steps on channel 3: 1.0 then 2.0
    set_spikes(3, 32'h3F800000);
    run_step(0, 0, lat);
    chk("t2_y1_ch0", cap_y1[0], 32'h3F800000);
    set_spikes(3, 32'h40000000);
    run_step(0, 0, lat);
    chk("t2_x2_ch3", cap_x2[3], 32'h3F800000);
    chk("t2_x1_ch3", cap_x1[3], 32'h40000000);

    // Tick mid-step and in the done cycle are both ignored
    run_step(0, 5, lat);
    chk("t3_done_lat", lat, 13);
    chk("t3_overrun", o_overrun, 1);
    clr_flags();
    chk("t3_clr", o_overrun, 0);
    run_step(0, DONE_REL, lat);
    chk("t3b_done_lat", lat, 13);
    chk("t3b_no_start", o_busy, 0);
    chk("t3b_overrun", o_overrun, 1);
    clr_flags();

    // Out-of-order result, then a stray result in idle
    bad_cyc = cyc + 2 + DP_LAT;
    run_step(0, 0, lat);
    chk("t4_seq_err", o_seq_err, 1);
    clr_flags();
    chk("t4_clr", o_seq_err, 0);
    i_rd_ch = 0;
    inj_cyc = cyc + 1;
    nxt();
    nxt();
    chk("t4_idle_seq_err", o_seq_err, 1);
    clr_flags();

    // Reset in cycle 7 of a step
    set_spikes(5, 32'h3F000000);
    d0 = done_cnt;
    tc = cyc;
    i_tick = 1'b1;
    nxt();
    i_tick = 1'b0;
    while (cyc < tc + 7) nxt();
    reset = 1'b1;
    nxt();
    chk("t5_busy", o_busy, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      i_rd_ch = CH_W'(i); #1;
      chk("t5_bank_zero", o_rd_force, 32'h0);
    end
    reset = 1'b0;
    repeat (20) nxt();
    chk("t5_no_done", done_cnt, d0);
    run_step(0, 0, lat);
    chk("t5_fresh_lat", lat, 13);

    // Randomized steps
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < NUM_CH; i++) spike_tab[i] = $urandom;
      run_step(1, 0, lat);
      chk("rnd_done_lat", lat, 13);
      repeat ($urandom_range(3)) begin
        i_rd_ch = CH_W'($urandom_range(NUM_CH - 1));
        nxt();
      end
    end

    nxt();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
